pipelined_adder_tree_acc: RTL and testbench

Parametrised, fully pipelined signed adder tree reducing N_IN operands to one sum, with a post-tree accumulator that sums multiple input beats, e.g. input-channel groups of a CNN convolution, into one result. It sits between the multiplier array and the bias/activation stage. It adds registered levels, a valid/ready handshake with backpressure, non-power-of-two input counts, and lossless width growth.

---
 rtl/pipelined_adder_tree_acc.sv | 135 +++++++++++++
 tb/tb_pipelined_adder_tree_acc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree_acc.sv
// Signed adder tree reducing N_IN operands per beat, followed by a multi-beat accumulator.
// Latency: LEVELS+1 cycles from acceptance of a last beat to out_valid (1 cycle when N_IN = 1).
// Backpressure: global stall; all stages hold while out_valid && !out_ready, and in_ready drops.
module pipelined_adder_tree_acc #(
  parameter int N_IN      = 256,
  parameter int IN_WIDTH  = 32,
  parameter int ACC_EXTRA = 8,
  localparam int LEVELS    = (N_IN > 1) ? $clog2(N_IN) : 0,
  localparam int OUT_WIDTH = IN_WIDTH + LEVELS + ACC_EXTRA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*IN_WIDTH-1:0] in_data,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     busy
);

  // Operand count rounded up to a power of two; the extra slots are fed zeros.
  localparam int NP = 1 << LEVELS;

  logic                 w_adv;
  logic [LEVELS:0]      w_pipe_vld;
  logic [OUT_WIDTH-1:0] w_tree_ext;
  logic [OUT_WIDTH-1:0] w_acc_next;
  logic                 w_tree_vld;
  logic                 w_tree_first;
  logic                 w_tree_last;
  logic [OUT_WIDTH-1:0] r_acc;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;

  // The whole pipeline moves only when the output slot is free or being drained.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Level 0 is the padded input; level k holds NP>>k partial sums of IN_WIDTH+k bits.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int W   = IN_WIDTH + k;
    localparam int CNT = NP >> k;

    logic [CNT*W-1:0] w_dat;
    logic             w_vld;
    logic             w_first;
    logic             w_last;

    if (k == 0) begin : g_in
      // Zero-pad the operand vector up to the power-of-two tree width.
      always_comb begin
        w_dat = '0;
        w_dat[N_IN*IN_WIDTH-1:0] = in_data;
      end
      assign w_vld   = in_valid;
      assign w_first = in_first;
      assign w_last  = in_last;
      // The input itself is not a pipeline slot, so it never counts towards busy.
      assign w_pipe_vld[k] = 1'b0;
    end else begin : g_add
      localparam int PW = W - 1;

      logic [CNT*W-1:0] w_sum;
      logic [CNT*W-1:0] r_dat;
      logic             r_vld;
      logic             r_first;
      logic             r_last;

      // Pairwise sums, each operand sign-extended by one bit so no level can overflow.
      always_comb begin
        w_sum = '0;
        for (int j = 0; j < CNT; j++) begin
          w_sum[j*W +: W] = W'($signed(g_lvl[k-1].w_dat[(2*j)*PW +: PW]))
                          + W'($signed(g_lvl[k-1].w_dat[(2*j+1)*PW +: PW]));
        end
      end

      // Stage register: data, valid and tags advance together on the global enable.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dat   <= '0;
          r_vld   <= 1'b0;
          r_first <= 1'b0;
          r_last  <= 1'b0;
        end else if (w_adv) begin
          r_dat   <= w_sum;
          r_vld   <= g_lvl[k-1].w_vld;
          r_first <= g_lvl[k-1].w_first;
          r_last  <= g_lvl[k-1].w_last;
        end
      end

      assign w_dat   = r_dat;
      assign w_vld   = r_vld;
      assign w_first = r_first;
      assign w_last  = r_last;
      assign w_pipe_vld[k] = r_vld;
    end
  end

  assign w_tree_vld   = g_lvl[LEVELS].w_vld;
  assign w_tree_first = g_lvl[LEVELS].w_first;
  assign w_tree_last  = g_lvl[LEVELS].w_last;
  assign w_tree_ext   = OUT_WIDTH'($signed(g_lvl[LEVELS].w_dat));

  // A first beat restarts the sum; otherwise keep adding, wrapping at OUT_WIDTH.
  assign w_acc_next = w_tree_first ? w_tree_ext : (r_acc + w_tree_ext);

  // Accumulate valid tree outputs and publish the running sum on a last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      if (w_tree_vld) begin
        r_acc <= w_acc_next;
      end
      if (w_tree_vld && w_tree_last) begin
        r_out_data  <= w_acc_next;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (|w_pipe_vld) || r_out_valid;

endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// Bench for pipelined_adder_tree_acc: a 256x32 instance and a 5x8 instance.
// Driver tasks push expected results into queues; monitors pop and compare on each output handshake.
// Stalls are produced by lowering out_ready; hold behaviour is checked while stalled.
module tb_pipelined_adder_tree_acc;

  localparam int AN = 256, AW = 32, AL = 8, AOW = AW + AL + 8;
  localparam int BN = 5,   BW = 8,  BL = 3, BOW = BW + BL + 8;

  typedef struct { longint val; int cyc; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic             a_in_valid = 1'b0, a_in_first = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b1;
  logic [AN*AW-1:0] a_in_data = '0;
  logic             a_in_ready, a_out_valid, a_busy;
  logic [AOW-1:0]   a_out_data;

  logic             b_in_valid = 1'b0, b_in_first = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1;
  logic [BN*BW-1:0] b_in_data = '0;
  logic             b_in_ready, b_out_valid, b_busy;
  logic [BOW-1:0]   b_out_data;

  pipelined_adder_tree_acc #(.N_IN(AN), .IN_WIDTH(AW), .ACC_EXTRA(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_first(a_in_first), .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .busy(a_busy)
  );

  pipelined_adder_tree_acc #(.N_IN(BN), .IN_WIDTH(BW), .ACC_EXTRA(8)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_first(b_in_first), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [AN*AW-1:0] fill_a(input logic [AW-1:0] v);
    logic [AN*AW-1:0] r;
    for (int i = 0; i < AN; i++) r[i*AW +: AW] = v;
    return r;
  endfunction

  // Issue one beat on DUT A; the expected result is queued when a last beat is accepted.
  task automatic send_a(input logic [AN*AW-1:0] d, input bit f, input bit l,
                        input longint exp, input bit lat, input bit push);
    int n = 0;
    a_in_data = d; a_in_first = f; a_in_last = l; a_in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!a_in_ready && n < 200);
    if (!a_in_ready) begin
      chk("a_in_ready_timeout", a_in_ready, 1);
      a_in_valid = 1'b0;
      return;
    end
    if (l && push) qa.push_back('{val: exp, cyc: lat ? cyc + AL + 1 : -1});
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [BN*BW-1:0] d, input bit f, input bit l,
                        input longint exp, input bit lat);
    int n = 0;
    b_in_data = d; b_in_first = f; b_in_last = l; b_in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!b_in_ready && n < 200);
    if (!b_in_ready) begin
      chk("b_in_ready_timeout", b_in_ready, 1);
      b_in_valid = 1'b0;
      return;
    end
    if (l) qb.push_back('{val: exp, cyc: lat ? cyc + BL + 1 : -1});
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((a_busy || b_busy) && n < 500);
    chk("idle_timeout_busy", a_busy | b_busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor for DUT A: compare each delivered result, and check holding during stalls.
  initial begin : mon_a
    bit             was_stalled = 1'b0;
    logic [AOW-1:0] held = '0;
    exp_t           e;
    longint         got;
    forever begin
      @(negedge clk);
      got = longint'($signed(a_out_data));
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_result", got, -999999);
        end else begin
          e = qa.pop_front();
          chk("a_out_data", got, e.val);
          if (e.cyc >= 0) chk("a_latency_cycle", cyc, e.cyc);
        end
      end
      if (a_out_valid && !a_out_ready) begin
        chk("a_stall_in_ready", a_in_ready, 0);
        if (was_stalled) chk("a_hold_out_data", got, longint'($signed(held)));
        was_stalled = 1'b1;
        held = a_out_data;
      end else begin
        was_stalled = 1'b0;
      end
    end
  end

  // Monitor for DUT B.
  initial begin : mon_b
    exp_t   e;
    longint got;
    forever begin
      @(negedge clk);
      got = longint'($signed(b_out_data));
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_result", got, -999999);
        end else begin
          e = qb.pop_front();
          chk("b_out_data", got, e.val);
          if (e.cyc >= 0) chk("b_latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [AN*AW-1:0] alt;
    int n;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_data", longint'(a_out_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 1);
    @(posedge clk);
    #1;

    // 1: all ones, single beat -> 256 after 9 cycles; busy asserted while in flight.
    send_a(fill_a(32'd1), 1, 1, 256, 1, 1);
    @(negedge clk);
    chk("t1_busy_in_flight", a_busy, 1);
    n = 0;
    while (!a_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t1_out_valid_seen", a_out_valid, 1);
    @(negedge clk);
    chk("t1_out_valid_drop", a_out_valid, 0);
    @(negedge clk);
    chk("t1_busy_fall", a_busy, 0);
    @(posedge clk);
    #1;

    // 2: alternating extremes; each pair sums to -1 -> -128 with no level overflow.
    for (int i = 0; i < AN; i++) alt[i*AW +: AW] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    send_a(alt, 1, 1, -128, 1, 1);
    wait_idle();

    // 3: three-beat accumulation of all-twos (512 per beat) -> single result 1536.
    send_a(fill_a(32'd2), 1, 0, 0, 0, 1);
    send_a(fill_a(32'd2), 0, 0, 0, 0, 1);
    send_a(fill_a(32'd2), 0, 1, 1536, 1, 1);
    wait_idle();

    // 4: stream of 20 single-beat results with a 5-cycle output stall mid-stream.
    fork
      begin
        for (int i = 0; i < 20; i++) send_a(fill_a(AW'(i)), 1, 1, 256 * i, 0, 1);
      end
      begin
        repeat (13) @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t4_stall_in_ready", a_in_ready, 0);
          @(posedge clk);
          #1;
        end
        a_out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("t4_queue_drained", qa.size(), 0);

    // 5: N_IN=5 with padding to 8 -> 635 in 4 cycles; all -128 -> -640.
    send_b({5{8'd127}}, 1, 1, 635, 1);
    wait_idle();
    send_b({5{8'h80}}, 1, 1, -640, 1);
    wait_idle();

    // 6: reset with a result stalled at the output and a partial accumulation in flight.
    a_out_ready = 1'b0;
    send_a(fill_a(32'd3), 1, 1, 768, 0, 0);
    send_a(fill_a(32'd1), 1, 0, 0, 0, 0);
    send_a(fill_a(32'd1), 0, 0, 0, 0, 0);
    n = 0;
    while (!a_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_stalled_result", a_out_valid, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_out_valid", a_out_valid, 0);
    chk("t6_async_busy", a_busy, 0);
    chk("t6_async_out_data", longint'(a_out_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    a_out_ready = 1'b1;
    send_a(fill_a(32'd5), 1, 1, 1280, 1, 1);
    wait_idle();

    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
